// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control FSM with memory handshake and retire counter
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic [5:0]       opCode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             ill_op,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t cur_state;
  state_t next_state;

  // Raw decoded controls before the reset gate on the enables/strobes.
  logic pc_write;
  logic pc_write_cond;
  logic mem_read_raw;
  logic mem_write_raw;
  logic ir_write_raw;
  logic reg_write_raw;
  logic ill_raw;
  logic retire;

  // State register; reset aborts any instruction in flight, including memory waits.
  always_ff @(posedge clkin) begin
    if (reset) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= next_state;
    end
  end

  // Retired-instruction counter, wraps naturally at CNT_W bits.
  always_ff @(posedge clkin) begin
    if (reset) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + CNT_ONE;
    end
  end

  // Next-state and Moore output decode; only FETCH looks at mem_ready for its strobes.
  always_comb begin
    next_state    = cur_state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    ill_raw       = 1'b0;
    retire        = 1'b0;
    IorD          = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    PCSource      = 2'b00;

    case (cur_state)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        ALUSrcB      = 2'b01;
        ir_write_raw = mem_ready;
        pc_write     = mem_ready;
        if (mem_ready) begin
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut here.
        ALUSrcB = 2'b11;
        case (opCode)
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_R:         next_state = S_R_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = S_I_EXEC;
          default: begin
            // PC already advanced in FETCH, so the bad word is simply skipped.
            next_state = S_FETCH;
            ill_raw    = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (opCode == OP_LW) begin
          next_state = S_MEM_RD;
        end else if (opCode == OP_SW) begin
          next_state = S_MEM_WR;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_MEM_RD: begin
        mem_read_raw = 1'b1;
        IorD         = 1'b1;
        if (mem_ready) begin
          next_state = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        reg_write_raw = 1'b1;
        MemtoReg      = 1'b1;
        next_state    = S_FETCH;
        retire        = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_raw = 1'b1;
        IorD          = 1'b1;
        if (mem_ready) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_R_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b10;
        next_state = S_R_WB;
      end
      S_R_WB: begin
        reg_write_raw = 1'b1;
        RegDst        = 1'b1;
        next_state    = S_FETCH;
        retire        = 1'b1;
      end
      S_I_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = S_I_WB;
      end
      S_I_WB: begin
        reg_write_raw = 1'b1;
        next_state    = S_FETCH;
        retire        = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 2'b01;
        pc_write_cond = 1'b1;
        PCSource      = 2'b01;
        next_state    = S_FETCH;
        retire        = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        PCSource   = 2'b10;
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      default: begin
        // Encodings 12-15 are unreachable; recover to FETCH.
        next_state = S_FETCH;
      end
    endcase
  end

  // Write enables and memory strobes are held off while reset is high.
  assign pc_en    = ~reset & (pc_write | (pc_write_cond & zero));
  assign MemRead  = ~reset & mem_read_raw;
  assign MemWrite = ~reset & mem_write_raw;
  assign IRWrite  = ~reset & ir_write_raw;
  assign RegWrite = ~reset & reg_write_raw;
  assign ill_op   = ~reset & ill_raw;
  assign state    = cur_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;
  localparam int CNT_W = 4;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEM_ADDR = 2, ST_MEM_RD = 3,
                 ST_MEM_WB = 4, ST_MEM_WR = 5, ST_R_EXEC = 6, ST_R_WB = 7,
                 ST_BRANCH = 8, ST_JUMP = 9, ST_I_EXEC = 10, ST_I_WB = 11;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

  logic clkin = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opCode = 6'd0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic ill_op;
  logic [CNT_W-1:0] instret;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clkin(clkin), .reset(reset), .opCode(opCode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .state(state),
    .ill_op(ill_op), .instret(instret)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    logic [19:0] outs;
    int          cnt;
  } exp_t;

  typedef struct {
    int st;
    bit mr;
  } cyc_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  int   retired = 0;

  logic [19:0] act;
  assign act = {state, pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                ALUSrcA, ALUSrcB, ALUOp, PCSource, ill_op};

  function automatic bit is_legal(logic [5:0] op);
    return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J || op == OP_ADDI;
  endfunction

  // Output table written straight from the per-state control description.
  function automatic logic [19:0] spec_outs(int st, bit mr, bit z, bit illegal);
    bit pce = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, rdst = 0, m2r = 0, rw = 0, sa = 0, ill = 0;
    logic [1:0] sb = 2'b00, op = 2'b00, ps = 2'b00;
    logic [3:0] s4 = st[3:0];
    case (st)
      ST_FETCH:    begin mrd = 1; sb = 2'b01; irw = mr; pce = mr; end
      ST_DECODE:   begin sb = 2'b11; ill = illegal; end
      ST_MEM_ADDR: begin sa = 1; sb = 2'b10; end
      ST_MEM_RD:   begin mrd = 1; iord = 1; end
      ST_MEM_WB:   begin rw = 1; m2r = 1; end
      ST_MEM_WR:   begin mwr = 1; iord = 1; end
      ST_R_EXEC:   begin sa = 1; op = 2'b10; end
      ST_R_WB:     begin rw = 1; rdst = 1; end
      ST_I_EXEC:   begin sa = 1; sb = 2'b10; end
      ST_I_WB:     begin rw = 1; end
      ST_BRANCH:   begin sa = 1; op = 2'b01; ps = 2'b01; pce = z; end
      ST_JUMP:     begin pce = 1; ps = 2'b10; end
      default:     ;
    endcase
    return {s4, pce, iord, mrd, mwr, irw, rdst, m2r, rw, sa, sb, op, ps, ill};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: one expected record per cycle while the scoreboard is live.
  always @(negedge clkin) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL underflow: DUT cycle with no expected record at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("outs", {12'd0, act}, {12'd0, e.outs});
        check("instret", {{(32-CNT_W){1'b0}}, instret}, e.cnt);
      end
    end
  end

  // Builds the cycle plan of one instruction from its opcode and wait counts, drives it,
  // and queues the expected per-cycle outputs. zmode: -1 random zero, else fixed.
  task automatic run_instr(logic [5:0] op, int fw, int rw, int zmode);
    cyc_t plan[$];
    bit illegal = !is_legal(op);
    for (int i = 0; i < fw; i++) plan.push_back('{ST_FETCH, 1'b0});
    plan.push_back('{ST_FETCH, 1'b1});
    plan.push_back('{ST_DECODE, 1'($urandom)});
    case (op)
      OP_LW: begin
        plan.push_back('{ST_MEM_ADDR, 1'($urandom)});
        for (int i = 0; i < rw; i++) plan.push_back('{ST_MEM_RD, 1'b0});
        plan.push_back('{ST_MEM_RD, 1'b1});
        plan.push_back('{ST_MEM_WB, 1'($urandom)});
      end
      OP_SW: begin
        plan.push_back('{ST_MEM_ADDR, 1'($urandom)});
        for (int i = 0; i < rw; i++) plan.push_back('{ST_MEM_WR, 1'b0});
        plan.push_back('{ST_MEM_WR, 1'b1});
      end
      OP_R: begin
        plan.push_back('{ST_R_EXEC, 1'($urandom)});
        plan.push_back('{ST_R_WB, 1'($urandom)});
      end
      OP_ADDI: begin
        plan.push_back('{ST_I_EXEC, 1'($urandom)});
        plan.push_back('{ST_I_WB, 1'($urandom)});
      end
      OP_BEQ: plan.push_back('{ST_BRANCH, 1'($urandom)});
      OP_J:   plan.push_back('{ST_JUMP, 1'($urandom)});
      default: ;
    endcase
    foreach (plan[k]) begin
      exp_t e;
      opCode    = op;
      mem_ready = plan[k].mr;
      zero      = (zmode < 0) ? 1'($urandom) : 1'(zmode);
      e.outs    = spec_outs(plan[k].st, plan[k].mr, zero, illegal);
      e.cnt     = retired % (1 << CNT_W);
      exp_q.push_back(e);
      @(posedge clkin);
      #1;
    end
    if (!illegal) retired++;
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
  endfunction

  initial begin
    logic [5:0] op;
    opCode    = 6'b101010;
    mem_ready = 1'b1;
    zero      = 1'b1;
    @(negedge clkin);
    check("rst_state", {28'd0, state}, 0);
    check("rst_instret", {{(32-CNT_W){1'b0}}, instret}, 0);
    check("rst_gates", {29'd0, pc_en, IRWrite, MemRead}, 0);
    @(posedge clkin);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    run_instr(OP_R, 0, 0, -1);
    run_instr(OP_LW, 2, 3, -1);
    run_instr(OP_BEQ, 0, 0, 1);
    run_instr(OP_BEQ, 0, 0, 0);
    run_instr(OP_J, 0, 0, -1);
    run_instr(6'b111111, 0, 0, -1);
    run_instr(OP_SW, 1, 2, -1);
    for (int n = 0; n < 17; n++) run_instr(OP_ADDI, 0, 0, -1);

    for (int n = 0; n < 70; n++) begin
      case ($urandom_range(0, 6))
        0: op = OP_R;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
        4: op = OP_J;
        5: op = OP_ADDI;
        default: begin
          op = 6'($urandom);
          while (is_legal(op)) op = 6'($urandom);
        end
      endcase
      run_instr(op, rand_wait(), rand_wait(), -1);
    end
    check("drain", exp_q.size(), 0);
    mon_en = 1'b0;

    // Reset during a stalled store.
    opCode    = OP_SW;
    mem_ready = 1'b1;
    @(posedge clkin); #1;
    @(posedge clkin); #1;
    mem_ready = 1'b0;
    @(posedge clkin); #1;
    @(negedge clkin);
    check("wr_state", {28'd0, state}, ST_MEM_WR);
    check("wr_memwrite", {31'd0, MemWrite}, 1);
    @(posedge clkin); #1;
    reset = 1'b1;
    @(negedge clkin);
    check("rst_wr_gates", {28'd0, MemWrite, MemRead, RegWrite, pc_en}, 0);
    @(posedge clkin); #1;
    check("rst_wr_state", {28'd0, state}, ST_FETCH);
    check("rst_wr_instret", {{(32-CNT_W){1'b0}}, instret}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM that sequences the shared MIPS datapath: one ALU and one unified instruction/data memory port, one step per clock. It replaces the single-cycle decoder for the multi-cycle CPU variant. It decodes `opCode`, drives every datapath mux and write enable from its state, and stalls on a ready handshake from memory. It also keeps a retired-instruction counter for bring-up.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clkin`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `opCode`  in  6  instruction bits [31:26], valid from IR after FETCH completes.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory has completed the current read or write this cycle.
- `pc_en`  out  1  PC load enable = `PCWrite | (PCWriteCond & zero)`.
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemRead`, `MemWrite`  out  1 each  memory request strobes.
- `IRWrite`  out  1  instruction register load.
- `RegDst`  out  1  write address select: 0 = rt, 1 = rd.
- `MemtoReg`  out  1  register write data select: 0 = ALUOut, 1 = MDR.
- `RegWrite`  out  1  register file write enable.
- `ALUSrcA`  out  1  ALU A select: 0 = PC, 1 = A.
- `ALUSrcB`  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `ALUOp`  out  2  00 = add, 01 = sub, 10 = funct.
- `PCSource`  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `state`  out  4  current state encoding, for debug.
- `ill_op`  out  1  one-cycle pulse when an unsupported opcode is decoded.
- `instret`  out  CNT_W  count of retired instructions.

## Operation
- Supported opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, j = 000010, addi = 001000.
- State encodings: FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5, R_EXEC = 6, R_WB = 7, BRANCH = 8, JUMP = 9, I_EXEC = 10, I_WB = 11. Encodings 12–15 are unreachable; if entered, go to FETCH.
- Every output signal not listed for a state below is 0 in that state.
- **FETCH**
  - Outputs: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - IRWrite and PCWrite equal `mem_ready`.
  - Stays in FETCH until `mem_ready` = 1, then goes to DECODE.
- **DECODE**
  - Outputs: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target into ALUOut).
  - Next state: lw/sw → MEM_ADDR; R → R_EXEC; beq → BRANCH; j → JUMP; addi → I_EXEC.
  - Any other opcode → FETCH, with `ill_op` = 1 for this cycle. The PC has already advanced, so the illegal instruction is skipped.
- **MEM_ADDR**: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next: lw → MEM_RD, sw → MEM_WR.
- **MEM_RD**: MemRead = 1, IorD = 1. Waits for `mem_ready`, then → MEM_WB.
- **MEM_WB**: RegWrite = 1, RegDst = 0, MemtoReg = 1. → FETCH; retires.
- **MEM_WR**: MemWrite = 1, IorD = 1. Waits for `mem_ready`, then → FETCH; retires.
- **R_EXEC**: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. → R_WB.
- **R_WB**: RegWrite = 1, RegDst = 1, MemtoReg = 0. → FETCH; retires.
- **I_EXEC**: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. → I_WB.
- **I_WB**: RegWrite = 1, RegDst = 0, MemtoReg = 0. → FETCH; retires.
- **BRANCH**: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01. → FETCH; retires whether taken or not.
- **JUMP**: PCWrite = 1, PCSource = 10. → FETCH; retires.
- **Memory request hold**: MemRead/MemWrite and IorD stay constant for every cycle of a wait.
- **instret**
  - Increments by 1 on each retiring transition.
  - Wraps from all-ones to 0.
  - Does not increment on an `ill_op` pulse.

## Timing
- Outputs are Moore-decoded from `state`. The exceptions are IRWrite and PCWrite in FETCH, which are gated combinationally by `mem_ready`.
- Clocks per instruction with `mem_ready` tied to 1:
  - lw: 5
  - sw, R, addi: 4
  - beq, j: 3
  - Each cycle with `mem_ready` = 0 in FETCH, MEM_RD or MEM_WR adds 1 cycle.
- **While `reset` = 1**
  - Outputs: pc_en, IRWrite, RegWrite, MemWrite, MemRead and ill_op are forced to 0.
  - Registers: on the clock edge, state ← FETCH and instret ← 0.
- **First cycle after `reset` falls**: state = FETCH, MemRead = 1, ALUSrcB = 01, all other outputs 0 except `mem_ready`-gated IRWrite/pc_en.
- **Reset asserted mid-instruction (including during a memory wait)**: aborts on that edge. No write enable is asserted in the reset cycle, and no retire is counted.
- `mem_ready` is ignored outside FETCH, MEM_RD and MEM_WR.
- `zero` affects only `pc_en`, and only in BRANCH.

## Test plan
- **Reset, no waits**: reset for 2 cycles, then an R-type with `mem_ready` = 1 → state sequence 0, 1, 6, 7, 0; RegWrite = 1 only in cycle 4 with RegDst = 1; instret = 1.
- **lw with waits**: lw with 2 wait cycles in FETCH and 3 in MEM_RD → 10 cycles total; MemRead/IorD stable through the waits; IRWrite is a single pulse; RegWrite with MemtoReg = 1 in the last cycle.
- **beq taken vs. not taken**: beq with `zero` = 1 → pc_en = 1 and PCSource = 01 in the BRANCH cycle; repeated with `zero` = 0 → pc_en = 0; 3 cycles each; instret +1 each.
- **Jump and illegal opcode**: j → pc_en = 1 and PCSource = 10 in the third cycle. opCode = 111111 → `ill_op` pulses in DECODE, next state FETCH, instret unchanged.
- **Reset mid-write**: assert reset while in MEM_WR with `mem_ready` = 0 → MemWrite drops to 0 in the reset cycle; state = FETCH after the edge; instret = 0.
- **Counter wrap**: CNT_W = 4, run 17 addi instructions → instret reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
